led_matrix_column_scanner: RTL and testbench

- Downstream consumer of the irrigation image decoder.
- Takes the three Y-symmetric column patterns (col_0, col_1, col_2) and time-multiplexes them onto the CPLD kit's 5x7 LED matrix.
- Drives one active-low column select and 7 row lines at a time, with a programmable dwell per column.
- Snapshots the image once per frame so a pattern change never tears mid-frame.

---
 rtl/led_matrix_column_scanner.sv | 169 ++++++++++++++++
 tb/tb_led_matrix_column_scanner.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_matrix_column_scanner.sv
// rtl/led_matrix_column_scanner.sv - time-multiplexes three symmetric column patterns onto a 5x7 LED matrix
// Optional anti-ghosting blank between columns: define SCAN_BLANKING_EN.
module led_matrix_column_scanner #(
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [6:0] col_0,
    input  logic [6:0] col_1,
    input  logic [6:0] col_2,
    output logic [4:0] column_sel,
    output logic [6:0] row_data,
    output logic       frame_start
);

    localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    if (DWELL_CYCLES < 1 || DWELL_CYCLES > 65535 || BLANK_CYCLES < 1 || BLANK_CYCLES > 255) begin : g_bad_param
        $error("led_matrix_column_scanner: DWELL_CYCLES or BLANK_CYCLES out of range");
    end

`ifdef SCAN_BLANKING_EN
    localparam int BLK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [BLK_W-1:0] BLANK_LAST = BLK_W'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    logic [BLK_W-1:0] r_blank_cnt;
`else
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;
`endif

    state_t           r_state;
    logic [2:0]       r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic [6:0]       r_snap0;
    logic [6:0]       r_snap1;
    logic [6:0]       r_snap2;
    logic [4:0]       r_column_sel;
    logic [6:0]       r_row_data;
    logic             r_frame_start;

    function automatic logic [6:0] col_data(input logic [2:0] idx, input logic [6:0] s0,
                                            input logic [6:0] s1, input logic [6:0] s2);
        case (idx)
            3'd2:       return s0;
            3'd1, 3'd3: return s1;
            default:    return s2;
        endcase
    endfunction

    // Next column to drive; leaving column 4 takes a fresh snapshot straight from the inputs.
    logic       w_wrap;
    logic [2:0] w_adv_idx;
    logic [6:0] w_adv_s0;
    logic [6:0] w_adv_s1;
    logic [6:0] w_adv_s2;
    logic [6:0] w_adv_row;
    logic [4:0] w_adv_sel;

    assign w_wrap    = (r_idx == 3'd4);
    assign w_adv_idx = w_wrap ? 3'd0 : 3'(r_idx + 3'd1);
    assign w_adv_s0  = w_wrap ? col_0 : r_snap0;
    assign w_adv_s1  = w_wrap ? col_1 : r_snap1;
    assign w_adv_s2  = w_wrap ? col_2 : r_snap2;
    assign w_adv_row = col_data(w_adv_idx, w_adv_s0, w_adv_s1, w_adv_s2);
    assign w_adv_sel = ~(5'b00001 << w_adv_idx);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_idx         <= 3'd0;
            r_cnt         <= '0;
            r_snap0       <= 7'h00;
            r_snap1       <= 7'h00;
            r_snap2       <= 7'h00;
            r_column_sel  <= 5'b11111;
            r_row_data    <= 7'h00;
            r_frame_start <= 1'b0;
`ifdef SCAN_BLANKING_EN
            r_blank_cnt   <= '0;
`endif
        end else begin
            r_frame_start <= 1'b0;
            if (!enable) begin
                r_state      <= ST_IDLE;
                r_idx        <= 3'd0;
                r_cnt        <= '0;
                r_column_sel <= 5'b11111;
                r_row_data   <= 7'h00;
`ifdef SCAN_BLANKING_EN
                r_blank_cnt  <= '0;
`endif
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state       <= ST_SCAN;
                        r_idx         <= 3'd0;
                        r_cnt         <= '0;
                        r_snap0       <= col_0;
                        r_snap1       <= col_1;
                        r_snap2       <= col_2;
                        r_column_sel  <= 5'b11110;
                        r_row_data    <= col_2;
                        r_frame_start <= 1'b1;
                    end
                    ST_SCAN: begin
                        if (r_cnt == DWELL_LAST) begin
                            r_cnt <= '0;
`ifdef SCAN_BLANKING_EN
                            r_state      <= ST_BLANK;
                            r_blank_cnt  <= '0;
                            r_column_sel <= 5'b11111;
                            r_row_data   <= 7'h00;
`else
                            r_idx         <= w_adv_idx;
                            r_snap0       <= w_adv_s0;
                            r_snap1       <= w_adv_s1;
                            r_snap2       <= w_adv_s2;
                            r_column_sel  <= w_adv_sel;
                            r_row_data    <= w_adv_row;
                            r_frame_start <= w_wrap;
`endif
                        end else begin
                            r_cnt <= CNT_W'(r_cnt + 1'b1);
                        end
                    end
`ifdef SCAN_BLANKING_EN
                    ST_BLANK: begin
                        if (r_blank_cnt == BLANK_LAST) begin
                            r_state       <= ST_SCAN;
                            r_blank_cnt   <= '0;
                            r_idx         <= w_adv_idx;
                            r_snap0       <= w_adv_s0;
                            r_snap1       <= w_adv_s1;
                            r_snap2       <= w_adv_s2;
                            r_column_sel  <= w_adv_sel;
                            r_row_data    <= w_adv_row;
                            r_frame_start <= w_wrap;
                        end else begin
                            r_blank_cnt <= BLK_W'(r_blank_cnt + 1'b1);
                        end
                    end
`endif
                    default: begin
                        r_state      <= ST_IDLE;
                        r_column_sel <= 5'b11111;
                        r_row_data   <= 7'h00;
                    end
                endcase
            end
        end
    end

    assign column_sel  = r_column_sel;
    assign row_data    = r_row_data;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_led_matrix_column_scanner.sv
// tb/tb_led_matrix_column_scanner.sv - self-checking bench for led_matrix_column_scanner (DWELL 4 and DWELL 1)
module tb_led_matrix_column_scanner;

    localparam int D_A = 4;
    localparam int D_B = 1;
    localparam int BLK = 2;
`ifdef SCAN_BLANKING_EN
    localparam int BK = BLK;
`else
    localparam int BK = 0;
`endif
    localparam logic [12:0] DARK = {5'b11111, 7'h00, 1'b0};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [6:0] c0 = 7'h00;
    logic [6:0] c1 = 7'h00;
    logic [6:0] c2 = 7'h00;
    logic [4:0] sel_a, sel_b;
    logic [6:0] row_a, row_b;
    logic       fs_a, fs_b;

    always #5 clk = ~clk;

    led_matrix_column_scanner #(.DWELL_CYCLES(D_A), .BLANK_CYCLES(BLK)) u_dut_a (
        .clk(clk), .reset(reset), .enable(enable), .col_0(c0), .col_1(c1), .col_2(c2),
        .column_sel(sel_a), .row_data(row_a), .frame_start(fs_a));

    led_matrix_column_scanner #(.DWELL_CYCLES(D_B), .BLANK_CYCLES(BLK)) u_dut_b (
        .clk(clk), .reset(reset), .enable(enable), .col_0(c0), .col_1(c1), .col_2(c2),
        .column_sel(sel_b), .row_data(row_b), .frame_start(fs_b));

    logic [12:0] got[2];
    assign got[0] = {sel_a, row_a, fs_a};
    assign got[1] = {sel_b, row_b, fs_b};

    int n_checks = 0;
    int n_errors = 0;

    // Reference: each active DUT is just "cycles since the last frame load" plus the image taken then.
    logic       m_act[2] = '{1'b0, 1'b0};
    int         m_t[2]   = '{0, 0};
    logic [6:0] m_s0[2], m_s1[2], m_s2[2];
    logic [12:0] e_vec[2];

    function automatic int dwell(input int k);
        return (k == 0) ? D_A : D_B;
    endfunction

    function automatic logic [12:0] exp_vec(input int d, input logic act, input int t,
                                            input logic [6:0] a0, input logic [6:0] a1, input logic [6:0] a2);
        int slot;
        int col;
        logic [4:0] s;
        logic [6:0] dat;
        slot = d + BK;
        col  = t / slot;
        if (!act || (t % slot) >= d) return DARK;
        s = ~(5'(1 << col));
        case (col)
            2:       dat = a0;
            1, 3:    dat = a1;
            default: dat = a2;
        endcase
        return {s, dat, (t == 0)};
    endfunction

    always @(posedge clk or posedge reset) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_act[k] = 1'b0;
                m_t[k]   = 0;
            end else if (!m_act[k]) begin
                if (enable) begin
                    m_act[k] = 1'b1;
                    m_t[k]   = 0;
                    m_s0[k] = c0; m_s1[k] = c1; m_s2[k] = c2;
                end
            end else if (!enable) begin
                m_act[k] = 1'b0;
            end else begin
                m_t[k] = m_t[k] + 1;
                if (m_t[k] == 5 * (dwell(k) + BK)) begin
                    m_t[k] = 0;
                    m_s0[k] = c0; m_s1[k] = c1; m_s2[k] = c2;
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++)
            e_vec[k] = exp_vec(dwell(k), m_act[k], m_t[k], m_s0[k], m_s1[k], m_s2[k]);
    end

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (got[k] !== DARK) begin
                n_errors++;
                $display("FAIL reset_dark dut%0d got %b expected %b", k, got[k], DARK);
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (got[k] !== e_vec[k]) begin
                    n_errors++;
                    $display("FAIL idle_dark dut%0d got %b expected %b", k, got[k], e_vec[k]);
                end
            end
        end
    endtask

    task automatic test_scan_pattern();
        int last[2] = '{-1, -1};
        c2 = 7'h7F; c1 = 7'h2A; c0 = 7'h55;
        enable = 1'b1;
        for (int cyc = 0; cyc < 64; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                n_checks++;
                if (got[0] !== {5'b11110, 7'h7F, 1'b1}) begin
                    n_errors++;
                    $display("FAIL first_column got %b expected %b", got[0], {5'b11110, 7'h7F, 1'b1});
                end
            end
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (got[k] !== e_vec[k]) begin
                    n_errors++;
                    $display("FAIL scan_pattern dut%0d cyc %0d got %b expected %b", k, cyc, got[k], e_vec[k]);
                end
                if (got[k][0]) begin
                    if (last[k] >= 0) begin
                        n_checks++;
                        if (cyc - last[k] != 5 * (dwell(k) + BK)) begin
                            n_errors++;
                            $display("FAIL frame_period dut%0d got %0d expected %0d", k, cyc - last[k], 5 * (dwell(k) + BK));
                        end
                    end
                    last[k] = cyc;
                end
            end
        end
    endtask

    task automatic test_midframe_change();
        bit found = 0;
        bit seen3 = 0;
        bit done = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            found = (sel_a == 5'b11011);
        end
        n_checks++;
        if (!found) begin
            n_errors++;
            $display("FAIL midframe_wait got timeout expected column 2");
        end
        c1 = 7'h11;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (got[k] !== e_vec[k]) begin
                    n_errors++;
                    $display("FAIL midframe_model dut%0d got %b expected %b", k, got[k], e_vec[k]);
                end
            end
            if (sel_a == 5'b10111 && !seen3) begin
                seen3 = 1;
                n_checks++;
                if (row_a !== 7'h2A) begin
                    n_errors++;
                    $display("FAIL midframe_col3 got %h expected %h", row_a, 7'h2A);
                end
            end
            if (sel_a == 5'b11101 && seen3) begin
                done = 1;
                n_checks++;
                if (row_a !== 7'h11) begin
                    n_errors++;
                    $display("FAIL nextframe_col1 got %h expected %h", row_a, 7'h11);
                end
            end
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL nextframe_wait got timeout expected column 1");
        end
    endtask

    task automatic test_enable_drop();
        bit found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            found = (sel_a == 5'b11011);
        end
        n_checks++;
        if (!found) begin
            n_errors++;
            $display("FAIL drop_wait got timeout expected column 2");
        end
        enable = 1'b0;
        c2 = 7'h3C;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (got[k] !== DARK || got[k] !== e_vec[k]) begin
                    n_errors++;
                    $display("FAIL drop_dark dut%0d got %b expected %b", k, got[k], DARK);
                end
            end
        end
        enable = 1'b1;
        @(negedge clk);
        n_checks++;
        if (got[0] !== {5'b11110, 7'h3C, 1'b1}) begin
            n_errors++;
            $display("FAIL reenable got %b expected %b", got[0], {5'b11110, 7'h3C, 1'b1});
        end
    endtask

    task automatic test_reset_midscan();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (got[k] !== e_vec[k]) begin
                    n_errors++;
                    $display("FAIL pre_reset dut%0d got %b expected %b", k, got[k], e_vec[k]);
                end
            end
        end
        #2 reset = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (got[k] !== DARK) begin
                n_errors++;
                $display("FAIL reset_async dut%0d got %b expected %b", k, got[k], DARK);
            end
        end
        c2 = 7'h19;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (got[0] !== {5'b11110, 7'h19, 1'b1}) begin
            n_errors++;
            $display("FAIL reset_restart got %b expected %b", got[0], {5'b11110, 7'h19, 1'b1});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 900; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (got[k] !== e_vec[k]) begin
                    n_errors++;
                    $display("FAIL random dut%0d cyc %0d got %b expected %b", k, i, got[k], e_vec[k]);
                end
            end
            n_checks++;
            if ($countones(~sel_a) > 1 || $countones(~sel_b) > 1) begin
                n_errors++;
                $display("FAIL one_hot got %b/%b expected at most one low bit", sel_a, sel_b);
            end
            if ($urandom_range(0, 3) == 0) begin
                c0 = 7'($urandom); c1 = 7'($urandom); c2 = 7'($urandom);
            end
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            if ($urandom_range(0, 149) == 0) begin
                #2 reset = 1'b1;
                #1;
                n_checks++;
                if (got[0] !== DARK || got[1] !== DARK) begin
                    n_errors++;
                    $display("FAIL random_reset got %b/%b expected %b", got[0], got[1], DARK);
                end
                @(negedge clk);
                reset = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_pattern();
        test_midframe_change();
        test_enable_drop();
        test_reset_midscan();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
